// File: rtl/lpc_pkg.sv
// ---------------------------------------------------------------------------
// lpc_pkg
// Shared definitions for the LPC I/O target controller: the FSM state
// encoding and the LAD nibble codes used on the bus.
// No ports (package).
// ---------------------------------------------------------------------------
package lpc_pkg;

    // Controller states, in the order a claimed cycle walks through them
    typedef enum logic [3:0] {
        IDLE,
        CYC,
        ADDR,
        WDATA,
        HTAR1,
        HTAR2,
        WAITSYNC,
        SYNC,
        RDATA,
        DTAR,
        IGNORE
    } lpc_state_e;

    // LAD nibble codes
    localparam logic [3:0] START      = 4'h0;
    localparam logic [3:0] CYC_IO_RD  = 4'h0;
    localparam logic [3:0] CYC_IO_WR  = 4'h2;
    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_SHORT = 4'h5;
    localparam logic [3:0] TAR        = 4'hF;

endpackage

// File: rtl/lpc_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// lpc_io_ctrl_if
// Groups the LPC bus pins and the register-file side of the I/O target.
//   LPC side     : lframe_n, lad_in (to target), lad_out, lad_oe (from target),
//                  lpc_en (decode enable, to target)
//   Register side: device_cs, io_rden, io_wren, addr, din (from target),
//                  dout (read data, to target)
//   Status       : busy (from target)
// Modports: slave = the controller, master = host/register-file side.
// ---------------------------------------------------------------------------
interface lpc_io_ctrl_if;

    logic       lframe_n;
    logic [3:0] lad_in;
    logic [3:0] lad_out;
    logic       lad_oe;
    logic       lpc_en;
    logic       device_cs;
    logic       io_rden;
    logic       io_wren;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;

    modport slave (
        input  lframe_n, lad_in, lpc_en, dout,
        output lad_out, lad_oe, device_cs, io_rden, io_wren, addr, din, busy
    );

    modport master (
        output lframe_n, lad_in, lpc_en, dout,
        input  lad_out, lad_oe, device_cs, io_rden, io_wren, addr, din, busy
    );

endinterface

// File: rtl/lpc_io_ctrl.sv
// ---------------------------------------------------------------------------
// lpc_io_ctrl
// LPC I/O-cycle target decoding a 256-byte window at {IO_BASE_HI, 8'hxx}.
// Writes and reads are turned into single-cycle register-file strobes during
// the host turnaround, followed by SYNC, read data (reads only) and the
// device turnaround.
//
// Ports:
//   lclk    - LPC clock, the only clock
//   lreset  - asynchronous active-high reset
//   bus     - lpc_io_ctrl_if.slave (LAD/LFRAME#, lpc_en, register-file
//             strobes/address/data, busy)
//
// Configuration macro:
//   LPC_WAIT_SYNC_EN - when defined, one short-wait SYNC (4'h5) is driven
//                      before the ready SYNC on every claimed cycle.
// ---------------------------------------------------------------------------
module lpc_io_ctrl
    import lpc_pkg::*;
#(
    parameter logic [7:0] IO_BASE_HI = 8'h0A
) (
    input logic          lclk,
    input logic          lreset,
    lpc_io_ctrl_if.slave bus
);

    lpc_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        isWrite_q, isWrite_d;
    logic [11:0] adrSh_q, adrSh_d;
    logic [3:0]  dataLo_q, dataLo_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        startSeen;
    logic [15:0] fullAddr;
    logic        ladOe;
    logic [3:0]  ladOut;

    assign startSeen = !bus.lframe_n && (bus.lad_in == START);
    // The last address nibble is still on LAD when the decode is made
    assign fullAddr  = {adrSh_q, bus.lad_in};

    // State and datapath registers; reset puts every output at its idle value
    // and, because LAD drive is decoded from state, releases LAD immediately.
    always_ff @(posedge lclk or posedge lreset) begin
        if (lreset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            isWrite_q <= 1'b0;
            adrSh_q   <= 12'h000;
            dataLo_q  <= 4'h0;
            addr_q    <= 8'h00;
            din_q     <= 8'h00;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isWrite_q <= isWrite_d;
            adrSh_q   <= adrSh_d;
            dataLo_q  <= dataLo_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic. LFRAME# low outside IDLE aborts whatever is in
    // progress and the same edge is re-examined as a possible START; IGNORE
    // is only left through a START so that foreign cycles are skipped whole.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isWrite_d = isWrite_q;
        adrSh_d   = adrSh_q;
        dataLo_d  = dataLo_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rdata_d   = rdata_q;

        if (state_q != IDLE && !bus.lframe_n) begin
            if (bus.lad_in == START) begin
                state_d = CYC;
            end else if (state_q != IGNORE) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (startSeen) begin
                        state_d = CYC;
                    end
                end
                CYC: begin
                    // Bit 0 of CYCTYPE is reserved and not decoded
                    if ({bus.lad_in[3:1], 1'b0} == CYC_IO_RD ||
                        {bus.lad_in[3:1], 1'b0} == CYC_IO_WR) begin
                        isWrite_d = bus.lad_in[1];
                        cnt_d     = 2'd0;
                        state_d   = ADDR;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                ADDR: begin
                    adrSh_d = {adrSh_q[7:0], bus.lad_in};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (bus.lpc_en && fullAddr[15:8] == IO_BASE_HI) begin
                            addr_d  = fullAddr[7:0];
                            cnt_d   = 2'd0;
                            state_d = isWrite_q ? WDATA : HTAR1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                WDATA: begin
                    if (!cnt_q[0]) begin
                        dataLo_d = bus.lad_in;
                        cnt_d    = 2'd1;
                    end else begin
                        din_d   = {bus.lad_in, dataLo_q};
                        state_d = HTAR1;
                    end
                end
                HTAR1: begin
                    state_d = HTAR2;
                end
                HTAR2: begin
                    // Register file presents read data the cycle after io_rden
                    if (!isWrite_q) begin
                        rdata_d = bus.dout;
                    end
                    cnt_d = 2'd0;
`ifdef LPC_WAIT_SYNC_EN
                    state_d = WAITSYNC;
`else
                    state_d = SYNC;
`endif
                end
                WAITSYNC: begin
                    state_d = SYNC;
                end
                SYNC: begin
                    cnt_d   = 2'd0;
                    state_d = isWrite_q ? DTAR : RDATA;
                end
                RDATA: begin
                    if (!cnt_q[0]) begin
                        cnt_d = 2'd1;
                    end else begin
                        state_d = DTAR;
                    end
                end
                DTAR: begin
                    state_d = IDLE;
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // LAD drive decoded from state; an undriven LAD always reads back 4'hF
    always_comb begin
        ladOe  = 1'b0;
        ladOut = TAR;
        case (state_q)
            WAITSYNC: begin
                ladOe  = 1'b1;
                ladOut = SYNC_SHORT;
            end
            SYNC: begin
                ladOe  = 1'b1;
                ladOut = SYNC_READY;
            end
            RDATA: begin
                ladOe  = 1'b1;
                ladOut = cnt_q[0] ? rdata_q[7:4] : rdata_q[3:0];
            end
            DTAR: begin
                ladOe  = 1'b1;
                ladOut = TAR;
            end
            default: begin
                ladOe  = 1'b0;
                ladOut = TAR;
            end
        endcase
    end

    // HTAR1 is visited once per claimed cycle, so each strobe is one cycle
    // long and only one kind can ever be active.
    assign bus.lad_oe    = ladOe;
    assign bus.lad_out   = ladOut;
    assign bus.device_cs = (state_q == HTAR1);
    assign bus.io_rden   = (state_q == HTAR1) && !isWrite_q;
    assign bus.io_wren   = (state_q == HTAR1) && isWrite_q;
    assign bus.addr      = addr_q;
    assign bus.din       = din_q;
    assign bus.busy      = state_q inside {ADDR, WDATA, HTAR1, HTAR2, WAITSYNC,
                                           SYNC, RDATA, DTAR};

endmodule

// File: tb/tb_lpc_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lpc_io_ctrl
// Directed bench for lpc_io_ctrl. Each host cycle is planned as a list of
// clock steps carrying both the LAD/LFRAME# stimulus and the expected target
// response; expectations are queued when a step is driven and popped once
// the DUT has reacted to that edge.
// Honours LPC_WAIT_SYNC_EN to expect the extra short-wait SYNC.
// ---------------------------------------------------------------------------
module tb_lpc_io_ctrl;
    import lpc_pkg::*;

    localparam logic [7:0] BASE_HI = 8'h0A;
    localparam logic [7:0] JUNK    = 8'hEE;
`ifdef LPC_WAIT_SYNC_EN
    localparam int WX = 1;
`else
    localparam int WX = 0;
`endif

    // {lad_oe, lad_out, device_cs, io_rden, io_wren}
    localparam logic [7:0] ZERO  = {1'b0, 4'hF, 3'b000};
    localparam logic [7:0] RDSTB = {1'b0, 4'hF, 3'b110};
    localparam logic [7:0] WRSTB = {1'b0, 4'hF, 3'b101};

    typedef struct {
        logic       lf;
        logic [3:0] lad;
        logic [7:0] dv;
        logic [7:0] vec;
        logic       busy;
        bit         chkBusy;
        bit         chkAddr;
        bit         chkDin;
        logic [7:0] ad;
        logic [7:0] dn;
    } step_t;

    logic  lclk;
    logic  lreset;
    int    vectors;
    int    miscompares;
    step_t plan[$];
    string planTag[$];
    step_t expQ[$];
    string tagQ[$];

    lpc_io_ctrl_if bus ();

    lpc_io_ctrl #(.IO_BASE_HI(BASE_HI)) dut (
        .lclk   (lclk),
        .lreset (lreset),
        .bus    (bus)
    );

    // Free-running LPC clock
    initial begin
        lclk = 1'b0;
        forever #5 lclk = ~lclk;
    end

    // Hard time limit so a stuck run still ends visibly
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] time limit");
    end

    function automatic logic [7:0] drv(input logic [3:0] v);
        return {1'b1, v, 3'b000};
    endfunction

    // Append one planned clock step to the current transaction
    function automatic void addStep(input string tag, input logic lf, input logic [3:0] lad,
                                    input logic [7:0] dv, input logic [7:0] vec, input logic busy,
                                    input bit cb, input bit ca, input bit cd,
                                    input logic [7:0] ad, input logic [7:0] dn);
        step_t s;
        s.lf = lf; s.lad = lad; s.dv = dv; s.vec = vec; s.busy = busy;
        s.chkBusy = cb; s.chkAddr = ca; s.chkDin = cd; s.ad = ad; s.dn = dn;
        plan.push_back(s);
        planTag.push_back(tag);
    endfunction

    function automatic void pushExp(input string tag, input step_t s);
        expQ.push_back(s);
        tagQ.push_back(tag);
    endfunction

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic checkOutput();
        step_t      e;
        string      t;
        logic [7:0] obs;
        vectors++;
        assert (expQ.size() != 0) else begin
            miscompares++;
            $error("[TB] FAIL sb_underflow: observed empty queue, expected an entry");
        end
        if (expQ.size() == 0) return;
        e   = expQ.pop_front();
        t   = tagQ.pop_front();
        obs = {bus.lad_oe, bus.lad_out, bus.device_cs, bus.io_rden, bus.io_wren};
        vectors++;
        assert (obs === e.vec) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed oe/lad/cs/rd/wr=%b, expected %b", t, obs, e.vec);
        end
        if (e.chkBusy) begin
            vectors++;
            assert (bus.busy === e.busy) else begin
                miscompares++;
                $error("[TB] FAIL %s_busy: observed %b, expected %b", t, bus.busy, e.busy);
            end
        end
        if (e.chkAddr) begin
            vectors++;
            assert (bus.addr === e.ad) else begin
                miscompares++;
                $error("[TB] FAIL %s_addr: observed %h, expected %h", t, bus.addr, e.ad);
            end
        end
        if (e.chkDin) begin
            vectors++;
            assert (bus.din === e.dn) else begin
                miscompares++;
                $error("[TB] FAIL %s_din: observed %h, expected %h", t, bus.din, e.dn);
            end
        end
    endtask

    // Drive one clock worth of host signals, then look at the result
    task automatic applyStimulus(input logic lf, input logic [3:0] lad, input logic [7:0] dv);
        bus.lframe_n = lf;
        bus.lad_in   = lad;
        bus.dout     = dv;
        @(posedge lclk);
        #1;
        checkOutput();
    endtask

    task automatic idleTicks(input int n);
        step_t s;
        s = '{lf: 1'b1, lad: 4'hF, dv: JUNK, vec: ZERO, busy: 1'b0, chkBusy: 1'b1,
              chkAddr: 1'b0, chkDin: 1'b0, ad: 8'h00, dn: 8'h00};
        for (int i = 0; i < n; i++) begin
            pushExp("idle", s);
            applyStimulus(1'b1, 4'hF, JUNK);
        end
    endtask

    // Pulse reset part-way through the current clock and check the outputs
    // fall to their reset values without waiting for an edge
    task automatic resetPulse();
        step_t s;
        s = '{lf: 1'b1, lad: 4'hF, dv: JUNK, vec: ZERO, busy: 1'b0, chkBusy: 1'b1,
              chkAddr: 1'b1, chkDin: 1'b1, ad: 8'h00, dn: 8'h00};
        #3;
        lreset = 1'b1;
        #1;
        pushExp("rst_async", s);
        checkOutput();
        bus.lframe_n = 1'b1;
        bus.lad_in   = 4'hF;
        @(posedge lclk);
        #1;
        pushExp("rst_hold", s);
        checkOutput();
        lreset = 1'b0;
    endtask

    // One host I/O cycle. abortAt/resetAt index the planned steps (-1 = none).
    task automatic ioCycle(input bit isWr, input logic [15:0] a, input logic [7:0] d,
                           input bit en, input bit skipStart, input int abortAt,
                           input bit abortStart, input int resetAt);
        bit    claim;
        step_t ab;
        claim = en && (a[15:8] == BASE_HI);
        bus.lpc_en = en;
        plan.delete();
        planTag.delete();
        if (!skipStart) addStep("start", 1'b0, START, JUNK, ZERO, 1'b0, 0, 0, 0, 8'h00, 8'h00);
        addStep("cyctype", 1'b1, isWr ? CYC_IO_WR : CYC_IO_RD, JUNK, ZERO, 1'b1, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (i < 3 || (claim && isWr))
                addStep("addr", 1'b1, a[15-4*i -: 4], JUNK, ZERO, 1'b1, 1, 0, 0, 8'h00, 8'h00);
            else if (!claim)
                addStep("decode_ignore", 1'b1, a[3:0], JUNK, ZERO, 1'b0, 0, 0, 0, 8'h00, 8'h00);
            else
                addStep("rd_strobe", 1'b1, a[3:0], JUNK, RDSTB, 1'b1, 1, 1, 0, a[7:0], 8'h00);
        end
        if (!claim) begin
            for (int i = 0; i < 6; i++)
                addStep("ignored", 1'b1, 4'hF, JUNK, ZERO, 1'b0, 0, 0, 0, 8'h00, 8'h00);
        end else begin
            if (isWr) begin
                addStep("wdata_lo", 1'b1, d[3:0], JUNK, ZERO, 1'b1, 1, 0, 0, 8'h00, 8'h00);
                addStep("wr_strobe", 1'b1, d[7:4], JUNK, WRSTB, 1'b1, 1, 1, 1, a[7:0], d);
            end
            addStep("htar2", 1'b1, 4'hF, JUNK, ZERO, 1'b1, 1, 0, 0, 8'h00, 8'h00);
`ifdef LPC_WAIT_SYNC_EN
            addStep("sync_wait", 1'b1, 4'hF, d, drv(SYNC_SHORT), 1'b1, 1, 0, 0, 8'h00, 8'h00);
            addStep("sync_ready", 1'b1, 4'hF, JUNK, drv(SYNC_READY), 1'b1, 1, 0, 0, 8'h00, 8'h00);
`else
            addStep("sync_ready", 1'b1, 4'hF, d, drv(SYNC_READY), 1'b1, 1, 0, 0, 8'h00, 8'h00);
`endif
            if (!isWr) begin
                addStep("rdata_lo", 1'b1, 4'hF, JUNK, drv(d[3:0]), 1'b1, 1, 0, 0, 8'h00, 8'h00);
                addStep("rdata_hi", 1'b1, 4'hF, JUNK, drv(d[7:4]), 1'b1, 1, 0, 0, 8'h00, 8'h00);
            end
            addStep("dev_tar", 1'b1, 4'hF, JUNK, drv(TAR), 1'b1, 1, 0, 0, 8'h00, 8'h00);
            addStep("release", 1'b1, 4'hF, JUNK, ZERO, 1'b0, 1, 0, 0, 8'h00, 8'h00);
        end
        for (int k = 0; k < plan.size(); k++) begin
            if (k == abortAt) begin
                ab = '{lf: 1'b0, lad: abortStart ? START : 4'hF, dv: JUNK, vec: ZERO, busy: 1'b0,
                       chkBusy: 1'b1, chkAddr: 1'b0, chkDin: 1'b0, ad: 8'h00, dn: 8'h00};
                pushExp("abort", ab);
                applyStimulus(1'b0, ab.lad, JUNK);
                return;
            end
            if (k == resetAt) begin
                resetPulse();
                return;
            end
            pushExp(planTag[k], plan[k]);
            applyStimulus(plan[k].lf, plan[k].lad, plan[k].dv);
        end
    endtask

    // Directed sequence of host cycles
    initial begin
        step_t rs;
        vectors      = 0;
        miscompares  = 0;
        lreset       = 1'b1;
        bus.lframe_n = 1'b1;
        bus.lad_in   = 4'hF;
        bus.lpc_en   = 1'b1;
        bus.dout     = JUNK;
        repeat (2) @(posedge lclk);
        #1;
        rs = '{lf: 1'b1, lad: 4'hF, dv: JUNK, vec: ZERO, busy: 1'b0, chkBusy: 1'b1,
               chkAddr: 1'b1, chkDin: 1'b1, ad: 8'h00, dn: 8'h00};
        pushExp("reset_state", rs);
        checkOutput();
        lreset = 1'b0;
        idleTicks(2);

        $display("[TB] write 0x0A01 <= 0x3C");
        ioCycle(1'b1, 16'h0A01, 8'h3C, 1'b1, 1'b0, -1, 1'b0, -1);
        idleTicks(1);

        $display("[TB] read 0x0A00 -> 0x02");
        ioCycle(1'b0, 16'h0A00, 8'h02, 1'b1, 1'b0, -1, 1'b0, -1);

        $display("[TB] read outside window and with decode disabled");
        ioCycle(1'b0, 16'h0B00, 8'h77, 1'b1, 1'b0, -1, 1'b0, -1);
        ioCycle(1'b0, 16'h0A00, 8'h77, 1'b0, 1'b0, -1, 1'b0, -1);

        $display("[TB] write aborted in second address nibble, then retried");
        ioCycle(1'b1, 16'h0A01, 8'h55, 1'b1, 1'b0, 3, 1'b0, -1);
        idleTicks(3);
        ioCycle(1'b1, 16'h0A01, 8'h3C, 1'b1, 1'b0, -1, 1'b0, -1);

        $display("[TB] read 0x0A06 -> 0xA9");
        ioCycle(1'b0, 16'h0A06, 8'hA9, 1'b1, 1'b0, -1, 1'b0, -1);

        $display("[TB] read aborted in SYNC by a new START, new read follows");
        ioCycle(1'b0, 16'h0A80, 8'h5A, 1'b1, 1'b0, 8 + WX, 1'b1, -1);
        ioCycle(1'b0, 16'h0AFF, 8'hC3, 1'b1, 1'b1, -1, 1'b0, -1);

        $display("[TB] reset pulsed during read SYNC");
        ioCycle(1'b0, 16'h0A10, 8'h81, 1'b1, 1'b0, -1, 1'b0, 8 + WX);
        idleTicks(1);
        ioCycle(1'b1, 16'h0A20, 8'h96, 1'b1, 1'b0, -1, 1'b0, -1);
        idleTicks(1);

        vectors++;
        assert (expQ.size() == 0) else begin
            miscompares++;
            $error("[TB] FAIL sb_drain: observed %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
